// File: rtl/rfb_pkg.sv
// -----------------------------------------------------------------------------
// rfb_pkg
// Shared definitions for the multi-issue register-file box.
//   rfb_aw()      : address width for a given register count (at least 1 bit)
//   rfb_slot_t    : index type for an issue/write slot
//   RF_RST_VAL    : register contents after reset
//   CNT_RST_VAL   : stable counter value after reset
// -----------------------------------------------------------------------------
package rfb_pkg;

    localparam int RF_RST_VAL  = 0;
    localparam int CNT_RST_VAL = 0;

    typedef logic [3:0] rfb_slot_t;

    function automatic int rfb_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_file_box_mp_if.sv
// -----------------------------------------------------------------------------
// reg_file_box_mp_if
// Bundles the ID/WB-side signals of the register-file box.
// There is no handshake: every signal is sampled or produced every cycle.
//   rd_addr_i  : NUM_RD packed read addresses (port k at [k*AW +: AW])
//   rd_data_o  : NUM_RD packed read data, combinational
//   rd_busy_o  : busy bit per read port, combinational
//   wr_en_i    : WB write enables, slot NUM_WR-1 is youngest
//   wr_addr_i  : WB write addresses
//   wr_data_i  : WB write data
//   sb_set_i   : ID issue, mark destination busy
//   sb_addr_i  : ID issue destination addresses
//   sb_flush_i : clear every busy bit
//   cnt_o      : free-running stable counter
// master = pipeline side, slave = register-file box.
// -----------------------------------------------------------------------------
interface reg_file_box_mp_if
    import rfb_pkg::*;
#(
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 64
);
    localparam int AW = rfb_aw(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic [NUM_WR-1:0]        wr_en_i;
    logic [NUM_WR*AW-1:0]     wr_addr_i;
    logic [NUM_WR*DATA_W-1:0] wr_data_i;
    logic [NUM_WR-1:0]        sb_set_i;
    logic [NUM_WR*AW-1:0]     sb_addr_i;
    logic                     sb_flush_i;
    logic [CNT_W-1:0]         cnt_o;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, sb_set_i, sb_addr_i, sb_flush_i,
        input  rd_data_o, rd_busy_o, cnt_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, sb_set_i, sb_addr_i, sb_flush_i,
        output rd_data_o, rd_busy_o, cnt_o
    );

endinterface

// File: rtl/stable_counter.sv
// -----------------------------------------------------------------------------
// stable_counter
// Free-running counter, cleared by reset, wraps naturally at 2^CNT_W.
//   clk   : clock
//   rst   : synchronous active-high reset
//   cnt_o : current count (registered)
// -----------------------------------------------------------------------------
module stable_counter
    import rfb_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_W'(CNT_RST_VAL);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/reg_file_box_mp.sv
// -----------------------------------------------------------------------------
// reg_file_box_mp
// N-wide register-file box at the ID/WB boundary: NUM_RD async read ports,
// NUM_WR write ports, a per-register busy scoreboard for issue interlock,
// optional same-cycle WB->ID bypass and a free-running stable counter.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, dominates every other input
//   rfb  : reg_file_box_mp_if.slave (reads, writes, busy set/flush, counter)
// r0 is hard-wired to zero and never busy; addresses >= NUM_REGS are ignored
// for writes/sets and read back as zero / not busy.
// -----------------------------------------------------------------------------
module reg_file_box_mp
    import rfb_pkg::*;
#(
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = 64
) (
    input logic              clk,
    input logic              rst,
    reg_file_box_mp_if.slave rfb
);

    localparam int   AW     = rfb_aw(NUM_REGS);
    localparam logic BYP_ON = (BYPASS != 0);

    // r0 has no storage at all, so indexing starts at 1.
    logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] r_busy;

    logic [DATA_W-1:0]   w_wd   [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] w_we;
    logic [NUM_REGS-1:1] w_set;
    logic [CNT_W-1:0]    w_cnt;

    // Per-register write/set decode. Slots are scanned in ascending order so
    // a later (younger) slot overrides data from an earlier one.
    always_comb begin
        w_we  = '0;
        w_set = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_wd[i] = '0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rfb.wr_en_i[j] && (rfb.wr_addr_i[j*AW +: AW] == AW'(i))) begin
                    w_we[i] = 1'b1;
                    w_wd[i] = rfb.wr_data_i[j*DATA_W +: DATA_W];
                end
                if (rfb.sb_set_i[j] && (rfb.sb_addr_i[j*AW +: AW] == AW'(i))) begin
                    w_set[i] = 1'b1;
                end
            end
        end
    end

    // Storage: flop array, one independent enable per register.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rst) begin
                r_regs[i] <= DATA_W'(RF_RST_VAL);
            end else if (w_we[i]) begin
                r_regs[i] <= w_wd[i];
            end
        end
    end

    // Scoreboard: flush > set > clear > hold. A set beats a clear because
    // the newly issued instruction is the producer that now owns the reg.
    always_ff @(posedge clk) begin
        if (rst || rfb.sb_flush_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_set | (r_busy & ~w_we);
        end
    end

    // Read ports. With bypass, a register being written this cycle returns the
    // write data, and its busy bit is hidden unless it is also being re-set.
    // A same-cycle set never raises busy: intra-bundle hazards belong to ID.
    always_comb begin
        rfb.rd_data_o = '0;
        rfb.rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rfb.rd_addr_i[k*AW +: AW] == AW'(i)) begin
                    if (BYP_ON && w_we[i]) begin
                        rfb.rd_data_o[k*DATA_W +: DATA_W] = w_wd[i];
                    end else begin
                        rfb.rd_data_o[k*DATA_W +: DATA_W] = r_regs[i];
                    end
                    rfb.rd_busy_o[k] = r_busy[i] & ~(BYP_ON & w_we[i] & ~w_set[i]);
                end
            end
        end
    end

    stable_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .cnt_o (w_cnt)
    );

    assign rfb.cnt_o = w_cnt;

endmodule

// File: tb/tb_reg_file_box_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_box_mp
// Two instances share one stimulus stream: dut_b1 (BYPASS=1, 64-bit counter)
// and dut_b0 (BYPASS=0, 8-bit counter). Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// Expected values go into exp_q when stimulus is driven and are popped in
// the same order when the outputs are sampled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file_box_mp;
    import rfb_pkg::*;

    localparam int NUM_RD   = 4;
    localparam int NUM_WR   = 2;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
    localparam int W        = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        sb_set;
    logic [NUM_WR*AW-1:0]     sb_addr;
    logic                     sb_flush;

    reg_file_box_mp_if #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DATA_W(DATA_W),
                         .NUM_REGS(NUM_REGS), .CNT_W(64)) if_b1 ();
    reg_file_box_mp_if #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DATA_W(DATA_W),
                         .NUM_REGS(NUM_REGS), .CNT_W(8))  if_b0 ();

    assign if_b1.rd_addr_i  = rd_addr;
    assign if_b1.wr_en_i    = wr_en;
    assign if_b1.wr_addr_i  = wr_addr;
    assign if_b1.wr_data_i  = wr_data;
    assign if_b1.sb_set_i   = sb_set;
    assign if_b1.sb_addr_i  = sb_addr;
    assign if_b1.sb_flush_i = sb_flush;
    assign if_b0.rd_addr_i  = rd_addr;
    assign if_b0.wr_en_i    = wr_en;
    assign if_b0.wr_addr_i  = wr_addr;
    assign if_b0.wr_data_i  = wr_data;
    assign if_b0.sb_set_i   = sb_set;
    assign if_b0.sb_addr_i  = sb_addr;
    assign if_b0.sb_flush_i = sb_flush;

    reg_file_box_mp #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DATA_W(DATA_W),
                      .NUM_REGS(NUM_REGS), .BYPASS(1), .CNT_W(64)) dut_b1 (
        .clk (clk),
        .rst (rst),
        .rfb (if_b1)
    );

    reg_file_box_mp #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DATA_W(DATA_W),
                      .NUM_REGS(NUM_REGS), .BYPASS(0), .CNT_W(8)) dut_b0 (
        .clk (clk),
        .rst (rst),
        .rfb (if_b0)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        sb_set   = '0;
        sb_addr  = '0;
        sb_flush = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
        rst = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
    endtask

    task automatic rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int j, input int a, input logic [DATA_W-1:0] d);
        wr_en[j]                    = 1'b1;
        wr_addr[j*AW +: AW]         = AW'(a);
        wr_data[j*DATA_W +: DATA_W] = d;
    endtask

    task automatic sb(input int j, input int a);
        sb_set[j]           = 1'b1;
        sb_addr[j*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DATA_W-1:0] rdata(input logic [NUM_RD*DATA_W-1:0] v, input int k);
        return v[k*DATA_W +: DATA_W];
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic push(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, e);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [DATA_W-1:0] mdl [NUM_REGS];

    initial begin
        int ra;
        int a0;
        int a1;
        bit e0;
        bit e1;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] byp;

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // --- reset: preload r5 (busy too), then reset while writing r6 ---
        step(); wr(0, 5, 32'h1234); sb(0, 5);
        step(); rd(0, 5);
        push(32'h1234); push(1);
        #1;
        check("preload_r5_b0", rdata(if_b0.rd_data_o, 0));
        check("preload_busy_b0", if_b0.rd_busy_o[0]);
        do_reset(); wr(1, 6, 32'h77); sb(1, 6); rd(0, 5);
        step(); rd(0, 5); rd(1, 6);
        push(0); push(0); push(0); push(0); push(0); push(0);
        #1;
        check("rst_r5_b1", rdata(if_b1.rd_data_o, 0));
        check("rst_r6_b0", rdata(if_b0.rd_data_o, 1));
        check("rst_busy_b1", if_b1.rd_busy_o);
        check("rst_busy_b0", if_b0.rd_busy_o);
        check("rst_cnt_b1", if_b1.cnt_o);
        check("rst_cnt_b0", if_b0.cnt_o);
        for (int c = 1; c <= 3; c++) begin
            step();
            push(W'(c));
            #1;
            check("cnt_after_rst", if_b1.cnt_o);
        end

        // --- write conflict: both slots to r7, youngest wins ---
        step(); wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); rd(0, 7);
        push(32'h5555); push(32'h0);
        #1;
        check("conflict_byp_b1", rdata(if_b1.rd_data_o, 0));
        check("conflict_old_b0", rdata(if_b0.rd_data_o, 0));
        push(32'h5555); push(32'h5555);
        step(); rd(0, 7);
        #1;
        check("conflict_r7_b1", rdata(if_b1.rd_data_o, 0));
        check("conflict_r7_b0", rdata(if_b0.rd_data_o, 0));

        // --- bypass vs registered read of r3 ---
        step(); wr(1, 3, 32'hDEAD); rd(1, 3);
        push(32'h0); push(32'hDEAD);
        #1;
        check("byp_old_b0", rdata(if_b0.rd_data_o, 1));
        check("byp_new_b1", rdata(if_b1.rd_data_o, 1));
        push(32'hDEAD);
        step(); wr(0, 3, 32'hBEEF); rd(3, 3);
        push(32'hBEEF);
        #1;
        check("byp_lat_b0", rdata(if_b0.rd_data_o, 3));
        check("byp_over_b1", rdata(if_b1.rd_data_o, 3));
        step(); rd(2, 3);
        push(32'hBEEF); push(32'hBEEF);
        #1;
        check("r3_final_b0", rdata(if_b0.rd_data_o, 2));
        check("r3_final_b1", rdata(if_b1.rd_data_o, 2));

        // --- scoreboard on r9 ---
        step(); sb(0, 9); rd(2, 9);
        push(0); push(0);
        #1;
        check("sb_set_same_b1", if_b1.rd_busy_o[2]);
        check("sb_set_same_b0", if_b0.rd_busy_o[2]);
        step(); rd(2, 9);
        push(1); push(1);
        #1;
        check("sb_busy_b1", if_b1.rd_busy_o[2]);
        check("sb_busy_b0", if_b0.rd_busy_o[2]);
        step(); wr(0, 9, 32'h99); sb(1, 9); rd(2, 9);
        push(1); push(1);
        #1;
        check("sb_setclr_b1", if_b1.rd_busy_o[2]);
        check("sb_setclr_b0", if_b0.rd_busy_o[2]);
        step(); wr(1, 9, 32'h9A); rd(2, 9); rd(0, 9);
        push(0); push(1); push(32'h9A); push(32'h99);
        #1;
        check("sb_clr_byp_b1", if_b1.rd_busy_o[2]);
        check("sb_clr_reg_b0", if_b0.rd_busy_o[2]);
        check("sb_data_b1", rdata(if_b1.rd_data_o, 0));
        check("sb_data_b0", rdata(if_b0.rd_data_o, 0));
        step(); rd(2, 9);
        push(0); push(0);
        #1;
        check("sb_idle_b1", if_b1.rd_busy_o[2]);
        check("sb_idle_b0", if_b0.rd_busy_o[2]);

        // --- flush beats a same-cycle set ---
        step(); sb(0, 4); sb(1, 6);
        step(); sb_flush = 1'b1; sb(0, 8); rd(0, 4); rd(1, 6);
        push(2'b11); push(2'b11);
        #1;
        check("pre_flush_b1", if_b1.rd_busy_o[1:0]);
        check("pre_flush_b0", if_b0.rd_busy_o[1:0]);
        step(); rd(0, 4); rd(1, 6); rd(2, 8);
        push(0); push(0);
        #1;
        check("post_flush_b1", if_b1.rd_busy_o[2:0]);
        check("post_flush_b0", if_b0.rd_busy_o[2:0]);

        // --- r0 is hard zero and never busy ---
        step(); wr(0, 0, 32'hFFFF); sb(1, 0); rd(0, 0);
        push(0); push(0); push(0); push(0);
        #1;
        check("r0_same_b1", rdata(if_b1.rd_data_o, 0));
        check("r0_same_b0", rdata(if_b0.rd_data_o, 0));
        check("r0_busy_same_b1", if_b1.rd_busy_o[0]);
        check("r0_busy_same_b0", if_b0.rd_busy_o[0]);
        step(); rd(0, 0); rd(1, 0);
        push(0); push(0); push(0);
        #1;
        check("r0_next_b1", rdata(if_b1.rd_data_o, 0));
        check("r0_next_b0", rdata(if_b0.rd_data_o, 1));
        check("r0_busy_next_b1", if_b1.rd_busy_o[1:0]);

        // --- random dual-slot writes against a reference model ---
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        for (int c = 0; c < 24; c++) begin
            step();
            a0 = $urandom_range(0, NUM_REGS - 1);
            a1 = (c % 3 == 0) ? a0 : $urandom_range(0, NUM_REGS - 1);
            ra = (c % 2 == 0) ? a1 : $urandom_range(0, NUM_REGS - 1);
            e0 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 1));
            d0 = $urandom;
            d1 = $urandom;
            rd(0, ra);
            if (e0) wr(0, a0, d0);
            if (e1) wr(1, a1, d1);
            byp = mdl[ra];
            if (ra != 0) begin
                if (e0 && a0 == ra) byp = d0;
                if (e1 && a1 == ra) byp = d1;
            end
            push(mdl[ra]); push(byp);
            #1;
            check("rnd_b0", rdata(if_b0.rd_data_o, 0));
            check("rnd_b1", rdata(if_b1.rd_data_o, 0));
            if (e0 && a0 != 0) mdl[a0] = d0;
            if (e1 && a1 != 0) mdl[a1] = d1;
        end

        // --- counter wrap on the 8-bit build ---
        do_reset();
        step();
        push(0);
        #1;
        check("wrap_start_b0", if_b0.cnt_o);
        repeat (255) step();
        push(8'hFF); push(255);
        #1;
        check("wrap_max_b0", if_b0.cnt_o);
        check("wrap_max_b1", if_b1.cnt_o);
        step();
        push(0); push(256);
        #1;
        check("wrap_zero_b0", if_b0.cnt_o);
        check("nowrap_b1", if_b1.cnt_o);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
